// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EXE stage and the RV32M multiply/divide unit.
// The pipeline side is the master and the execution unit is the slave.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      fun3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            ready;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, fun3, op_a, op_b, flush,
    input  ready, busy, done, result
  );

  modport slave (
    input  start, fun3, op_a, op_b, flush,
    output ready, busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply (or single-cycle when
// FAST_MUL=1) and restoring division, both on sign-stripped magnitudes with a final sign fix-up.
module muldiv_unit #(
  parameter int XLEN     = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  muldiv_unit_if.slave bus
);

  localparam int              CW       = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   LAST_IT  = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      fun3_q, fun3_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] mag_b_q, mag_b_d;
  logic            neg_q, neg_d;
  logic            rem_neg_q, rem_neg_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            in_is_div;
  logic            in_a_signed, in_b_signed;
  logic            in_a_neg, in_b_neg;
  logic [XLEN-1:0] in_mag_a, in_mag_b;
  logic            in_div_zero, in_ovf;
  logic [XLEN-1:0] in_special_res;
  logic [2*XLEN-1:0] fast_prod;

  logic [XLEN:0]   div_trial;
  logic            div_borrow;
  logic [XLEN:0]   mul_sum;
  logic [XLEN-1:0] hi_step, lo_step;

  function automatic logic [XLEN-1:0] mul_select(input logic [2:0] f3, input logic neg,
                                                 input logic [2*XLEN-1:0] prod);
    logic [2*XLEN-1:0] p;
    p = neg ? -prod : prod;
    return (f3[1:0] == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  function automatic logic [XLEN-1:0] div_select(input logic [2:0] f3, input logic q_neg,
                                                 input logic r_neg, input logic [XLEN-1:0] rem,
                                                 input logic [XLEN-1:0] quo);
    logic [XLEN-1:0] q, r;
    q = q_neg ? -quo : quo;
    r = r_neg ? -rem : rem;
    return f3[1] ? r : q;
  endfunction

  // Decode the incoming request: signedness, magnitudes and the divide special cases.
  always_comb begin
    in_is_div   = bus.fun3[2];
    in_a_signed = (bus.fun3 == 3'b001) || (bus.fun3 == 3'b010) ||
                  (bus.fun3 == 3'b100) || (bus.fun3 == 3'b110);
    in_b_signed = (bus.fun3 == 3'b001) || (bus.fun3 == 3'b100) || (bus.fun3 == 3'b110);
    in_a_neg    = in_a_signed && bus.op_a[XLEN-1];
    in_b_neg    = in_b_signed && bus.op_b[XLEN-1];
    in_mag_a    = in_a_neg ? -bus.op_a : bus.op_a;
    in_mag_b    = in_b_neg ? -bus.op_b : bus.op_b;
    in_div_zero = in_is_div && (bus.op_b == '0);
    in_ovf      = in_is_div && !bus.fun3[0] && (bus.op_a == MIN_NEG) && (bus.op_b == '1);
    if (in_div_zero) begin
      in_special_res = bus.fun3[1] ? bus.op_a : '1;
    end else begin
      in_special_res = bus.fun3[1] ? '0 : bus.op_a;
    end
  end

  if (FAST_MUL) begin : g_fast_mul
    assign fast_prod = {{XLEN{1'b0}}, in_mag_a} * {{XLEN{1'b0}}, in_mag_b};
  end else begin : g_iter_mul
    assign fast_prod = '0;
  end

  // One iteration: hi holds the partial remainder / upper product, lo the quotient / multiplier.
  always_comb begin
    div_trial  = {hi_q, lo_q[XLEN-1]} - {1'b0, mag_b_q};
    div_borrow = div_trial[XLEN];
    mul_sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_b_q} : '0);
    if (fun3_q[2]) begin
      hi_step = div_borrow ? {hi_q[XLEN-2:0], lo_q[XLEN-1]} : div_trial[XLEN-1:0];
      lo_step = {lo_q[XLEN-2:0], ~div_borrow};
    end else begin
      hi_step = mul_sum[XLEN:1];
      lo_step = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fun3_d    = fun3_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mag_b_d   = mag_b_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    result_d  = result_q;

    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        CALC: begin
          hi_d  = hi_step;
          lo_d  = lo_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_IT) begin
            state_d  = DONE;
            result_d = fun3_q[2] ? div_select(fun3_q, neg_q, rem_neg_q, hi_step, lo_step)
                                 : mul_select(fun3_q, neg_q, {hi_step, lo_step});
          end
        end
        IDLE, DONE: begin
          if (bus.start) begin
            fun3_d    = bus.fun3;
            neg_d     = in_a_neg ^ in_b_neg;
            rem_neg_d = in_a_neg;
            hi_d      = '0;
            cnt_d     = '0;
            // Multiply keeps the multiplicand in mag_b; divide keeps the divisor there.
            lo_d      = in_is_div ? in_mag_a : in_mag_b;
            mag_b_d   = in_is_div ? in_mag_b : in_mag_a;
            if (in_div_zero || in_ovf) begin
              state_d  = DONE;
              result_d = in_special_res;
            end else if (FAST_MUL && !in_is_div) begin
              state_d  = DONE;
              result_d = mul_select(bus.fun3, in_a_neg ^ in_b_neg, fast_prod);
            end else begin
              state_d = CALC;
            end
          end else if (state_q == DONE) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    ready_d = (state_d != CALC);
    busy_d  = (state_d == CALC);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      fun3_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      mag_b_q   <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fun3_q    <= fun3_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      mag_b_q   <= mag_b_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.ready  = ready_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule
